// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : state encodings and pipeline control patterns for hazard_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 16;
  localparam int STATE_W             = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT       = 3'd0,
    ST_RUN        = 3'd1,
    ST_LOAD_STALL = 3'd2,
    ST_MEM_WAIT   = 3'd3,
    ST_ERROR      = 3'd4
  } state_t;

  // A flush loads a bubble: every control bit of the target register becomes 0.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t c_ctrl_reset  = 7'b0000_111;
  localparam ctrl_t c_ctrl_run    = 7'b1111_000;
  localparam ctrl_t c_ctrl_branch = 7'b1111_100;
  localparam ctrl_t c_ctrl_load   = 7'b0011_010;
  localparam ctrl_t c_ctrl_freeze = 7'b0000_001;
  localparam ctrl_t c_ctrl_halt   = 7'b0000_000;

  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] idex_rt,
    input logic [4:0] ifid_rs,
    input logic [4:0] ifid_rt
  );
    return mem_read && (idex_rt != 5'd0) &&
           ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : enabled up-counter that sticks at all-ones, async active-low clear
// Revision 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline write-enable / flush sequencing for load-use stalls,
//               branch/jump flushes and data-memory waits with timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             dmem_ack_i,
  output logic             PC_we_o,
  output logic             IFID_we_o,
  output logic             IDEX_we_o,
  output logic             EXMEM_we_o,
  output logic             IFID_flush_o,
  output logic             IDEX_flush_o,
  output logic             MEMWB_flush_o,
  output logic             dmem_req_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_wait_one = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_next_wait;
  ctrl_t             w_ctrl;
  logic              w_mem_op;
  logic              w_load_use;
  logic              w_redirect;
  logic              w_req;
  logic              w_err;
  logic              w_stall_en;

  assign w_mem_op   = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign w_load_use = load_use_hazard(IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i);
  assign w_redirect = Branch_i | Jump_i;

  always_comb begin
    w_ctrl       = c_ctrl_reset;
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_req        = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_next_state = ST_RUN;
        w_next_wait  = '0;
      end
      ST_RUN, ST_LOAD_STALL: begin
        w_req = w_mem_op;
        // Memory wait outranks load-use, which outranks redirect; the losers
        // are held upstream and re-presented once the pipeline moves.
        if (w_mem_op && !dmem_ack_i) begin
          w_ctrl       = c_ctrl_freeze;
          w_next_state = ST_MEM_WAIT;
          w_next_wait  = c_wait_one;
        end else if ((r_state == ST_RUN) && w_load_use) begin
          w_ctrl       = c_ctrl_load;
          w_next_state = ST_LOAD_STALL;
        end else begin
          w_ctrl       = w_redirect ? c_ctrl_branch : c_ctrl_run;
          w_next_state = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        w_req = w_mem_op;
        if (dmem_ack_i) begin
          w_ctrl       = c_ctrl_run;
          w_next_state = ST_RUN;
          w_next_wait  = '0;
        end else begin
          w_ctrl = c_ctrl_freeze;
          if (r_wait_cnt >= c_wait_max) begin
            w_next_state = ST_ERROR;
          end else begin
            w_next_wait = r_wait_cnt + c_wait_one;
          end
        end
      end
      ST_ERROR: begin
        w_ctrl = c_ctrl_halt;
        w_err  = 1'b1;
      end
      default: begin
        w_next_state = ST_INIT;
        w_next_wait  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_INIT;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
    end
  end

  assign w_stall_en = !w_ctrl.pc_we &&
                      ((r_state == ST_RUN) || (r_state == ST_LOAD_STALL) ||
                       (r_state == ST_MEM_WAIT));

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (w_stall_en),
    .count (stall_cnt_o)
  );

  assign PC_we_o       = w_ctrl.pc_we;
  assign IFID_we_o     = w_ctrl.ifid_we;
  assign IDEX_we_o     = w_ctrl.idex_we;
  assign EXMEM_we_o    = w_ctrl.exmem_we;
  assign IFID_flush_o  = w_ctrl.ifid_flush;
  assign IDEX_flush_o  = w_ctrl.idex_flush;
  assign MEMWB_flush_o = w_ctrl.memwb_flush;
  assign dmem_req_o    = w_req;
  assign timeout_err_o = w_err;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed vectors with a scoreboard queue for hazard_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // {PC_we, IFID_we, IDEX_we, EXMEM_we, IFID_flush, IDEX_flush, MEMWB_flush}
  localparam logic [6:0] C_RST = 7'b0000_111;
  localparam logic [6:0] C_RUN = 7'b1111_000;
  localparam logic [6:0] C_BR  = 7'b1111_100;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_FRZ = 7'b0000_001;
  localparam logic [6:0] C_ERR = 7'b0000_000;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             IDEX_MemRead_i = 1'b0;
  logic [4:0]       IDEX_Rt_i = '0;
  logic [4:0]       IFID_Rs_i = '0;
  logic [4:0]       IFID_Rt_i = '0;
  logic             Branch_i = 1'b0;
  logic             Jump_i = 1'b0;
  logic             EXMEM_MemRead_i = 1'b0;
  logic             EXMEM_MemWrite_i = 1'b0;
  logic             dmem_ack_i = 1'b0;
  logic             PC_we_o, IFID_we_o, IDEX_we_o, EXMEM_we_o;
  logic             IFID_flush_o, IDEX_flush_o, MEMWB_flush_o;
  logic             dmem_req_o, timeout_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .IDEX_MemRead_i   (IDEX_MemRead_i),
    .IDEX_Rt_i        (IDEX_Rt_i),
    .IFID_Rs_i        (IFID_Rs_i),
    .IFID_Rt_i        (IFID_Rt_i),
    .Branch_i         (Branch_i),
    .Jump_i           (Jump_i),
    .EXMEM_MemRead_i  (EXMEM_MemRead_i),
    .EXMEM_MemWrite_i (EXMEM_MemWrite_i),
    .dmem_ack_i       (dmem_ack_i),
    .PC_we_o          (PC_we_o),
    .IFID_we_o        (IFID_we_o),
    .IDEX_we_o        (IDEX_we_o),
    .EXMEM_we_o       (EXMEM_we_o),
    .IFID_flush_o     (IFID_flush_o),
    .IDEX_flush_o     (IDEX_flush_o),
    .MEMWB_flush_o    (MEMWB_flush_o),
    .dmem_req_o       (dmem_req_o),
    .timeout_err_o    (timeout_err_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  typedef struct {
    string            name;
    logic [6:0]       ctrl;
    logic             req;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic vec_valid = 1'b0;
  logic drive_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string nm, input logic rst, input logic ld, input logic [4:0] xrt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br, input logic jp,
                      input logic emr, input logic emw, input logic ack,
                      input logic [6:0] ectrl, input logic ereq, input logic eerr, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_i = rst; IDEX_MemRead_i = ld; IDEX_Rt_i = xrt; IFID_Rs_i = rs; IFID_Rt_i = rt;
    Branch_i = br; Jump_i = jp; EXMEM_MemRead_i = emr; EXMEM_MemWrite_i = emw; dmem_ack_i = ack;
    e.name = nm; e.ctrl = ectrl; e.req = ereq; e.err = eerr; e.cnt = CNT_W'(ecnt);
    exp_q.push_back(e);
    vec_valid = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (vec_valid) begin
        checks++;
        act = {PC_we_o, IFID_we_o, IDEX_we_o, EXMEM_we_o, IFID_flush_o, IDEX_flush_o, MEMWB_flush_o};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL underflow: output presented with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          if (act !== e.ctrl || dmem_req_o !== e.req || timeout_err_o !== e.err || stall_cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL %s: got ctrl=%b req=%b err=%b cnt=%0d, expected ctrl=%b req=%b err=%b cnt=%0d",
                     e.name, act, dmem_req_o, timeout_err_o, stall_cnt_o, e.ctrl, e.req, e.err, e.cnt);
          end
        end
      end
      if (drive_done && !vec_valid) break;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    //    name          rst ld xrt rs rt br jp emr emw ack  ctrl   req err cnt
    step("reset",        0, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_RST, 0,  0,  0);
    step("init",         1, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RST, 0,  0,  0);
    step("run_idle",     1, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RUN, 0,  0,  0);
    step("lu_rs",        1, 1, 8,  8, 0, 0, 0, 0,  0,  0,   C_LU,  0,  0,  0);
    step("lu_masked",    1, 1, 8,  8, 0, 0, 0, 0,  0,  0,   C_RUN, 0,  0,  1);
    step("lu_rt_zero",   1, 1, 0,  0, 3, 0, 0, 0,  0,  0,   C_RUN, 0,  0,  1);
    step("lu_rt_br",     1, 1, 5,  1, 5, 1, 0, 0,  0,  0,   C_LU,  0,  0,  1);
    step("br_after_lu",  1, 0, 0,  0, 0, 1, 0, 0,  0,  0,   C_BR,  0,  0,  2);
    step("jump",         1, 0, 0,  0, 0, 0, 1, 0,  0,  0,   C_BR,  0,  0,  2);
    step("no_load_match",1, 0, 7,  7, 7, 0, 0, 0,  0,  0,   C_RUN, 0,  0,  2);

    step("reset_b",      0, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RST, 0,  0,  0);
    step("init_b",       1, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RST, 0,  0,  0);
    step("mem_req_br",   1, 0, 0,  0, 0, 1, 0, 1,  0,  0,   C_FRZ, 1,  0,  0);
    step("mem_wait1",    1, 0, 0,  0, 0, 1, 0, 1,  0,  0,   C_FRZ, 1,  0,  1);
    step("mem_wait2",    1, 0, 0,  0, 0, 1, 0, 1,  0,  0,   C_FRZ, 1,  0,  2);
    step("mem_ack",      1, 0, 0,  0, 0, 1, 0, 1,  0,  1,   C_RUN, 1,  0,  3);
    step("br_after_ack", 1, 0, 0,  0, 0, 1, 0, 0,  0,  0,   C_BR,  0,  0,  3);
    step("ack_same_cyc", 1, 0, 0,  0, 0, 0, 0, 0,  1,  1,   C_RUN, 1,  0,  3);
    step("ack_lu",       1, 1, 9,  0, 9, 0, 0, 0,  1,  1,   C_LU,  1,  0,  3);
    step("ls_mem_wait",  1, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_FRZ, 1,  0,  4);
    step("ls_mem_ack",   1, 0, 0,  0, 0, 0, 0, 1,  0,  1,   C_RUN, 1,  0,  5);

    step("to_req",       1, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_FRZ, 1,  0,  5);
    step("to_wait1",     1, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_FRZ, 1,  0,  6);
    step("to_wait2",     1, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_FRZ, 1,  0,  7);
    step("to_wait3",     1, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_FRZ, 1,  0,  8);
    step("to_wait4",     1, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_FRZ, 1,  0,  9);
    step("error",        1, 0, 0,  0, 0, 0, 0, 1,  0,  0,   C_ERR, 0,  1, 10);
    step("error_ack",    1, 0, 0,  0, 0, 1, 0, 1,  0,  1,   C_ERR, 0,  1, 10);
    step("error_held",   1, 1, 4,  4, 0, 0, 0, 0,  0,  0,   C_ERR, 0,  1, 10);

    step("reset_d",      0, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RST, 0,  0,  0);
    step("init_d",       1, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RST, 0,  0,  0);
    step("mw_req",       1, 0, 0,  0, 0, 0, 0, 0,  1,  0,   C_FRZ, 1,  0,  0);
    step("mw_wait",      1, 0, 0,  0, 0, 0, 0, 0,  1,  0,   C_FRZ, 1,  0,  1);
    step("mw_async_rst", 0, 0, 0,  0, 0, 0, 0, 0,  1,  0,   C_RST, 0,  0,  0);
    step("mw_init",      1, 0, 0,  0, 0, 0, 0, 0,  1,  0,   C_RST, 0,  0,  0);
    step("mw_run",       1, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RUN, 0,  0,  0);

    // Repeated one-cycle load stalls drive the 4-bit counter into saturation.
    for (int i = 0; i < 17; i++) begin
      step("sat_lu",     1, 1, 2,  2, 0, 0, 0, 0,  0,  0,   C_LU,  0,  0, (i < 15) ? i : 15);
      step("sat_ls",     1, 0, 0,  0, 0, 0, 0, 0,  0,  0,   C_RUN, 0,  0, (i + 1 < 15) ? i + 1 : 15);
    end

    @(posedge clk);
    #1;
    vec_valid  = 1'b0;
    drive_done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
